// File: rtl/p4_router_pkg.sv
// Shared router types: user metadata layout, egress index type and the
// egress-demux FSM state encoding.
package p4_router_pkg;

    localparam int EGR_SPEC_ID_WIDTH   = 8;
    localparam int USER_METADATA_WIDTH = 32;
    localparam int NUM_EGR_PORTS       = 11;

    typedef logic [EGR_SPEC_ID_WIDTH-1:0] egr_idx_t;

    localparam egr_idx_t EGR_DROP_ID = 8'hFF;

    // Egress spec sits in the low bits so it is md[0 +: EGR_SPEC_ID_WIDTH].
    typedef struct packed {
        logic [USER_METADATA_WIDTH-EGR_SPEC_ID_WIDTH-1:0] rsvd;
        egr_idx_t                                         egress_spec;
    } USER_META_DATA_METADATA_T;

    typedef enum logic [1:0] {
        DEMUX_IDLE,
        DEMUX_FWD,
        DEMUX_DROP
    } demux_state_t;

    function automatic logic egr_is_valid(input egr_idx_t idx, input egr_idx_t num_egr);
        return (idx != EGR_DROP_ID) && (idx < num_egr);
    endfunction

endpackage

// File: rtl/p4_router_egress_demux_if.sv
// AXI-Stream bundle with a per-port valid/ready vector so a single interface
// type serves both the single ingress stream and the one-hot egress fan-out.
interface p4_router_egress_demux_if #(
    parameter int DATA_BYTES = 8,
    parameter int VALID_W    = 1
) ();

    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic [VALID_W-1:0]      tvalid;
    logic [VALID_W-1:0]      tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/p4_router_md_fifo.sv
// Small first-word-fall-through metadata FIFO with async reset; rd_data shows
// the head entry whenever empty is low. Writes while full are ignored.
module p4_router_md_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Simultaneous write and pop leave occupancy unchanged.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/p4_router_egress_demux.sv
// Steers whole packets from the VNP4 output stream to one of NUM_EGR egress
// ports using queued per-packet metadata; invalid egress indices are dropped.
module p4_router_egress_demux
    import p4_router_pkg::*;
#(
    parameter int DATA_BYTES    = 8,
    parameter int NUM_EGR       = NUM_EGR_PORTS,
    parameter int MD_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  USER_META_DATA_METADATA_T      md_in,
    input  logic                          md_in_valid,
    p4_router_egress_demux_if.slave       s_axis,
    p4_router_egress_demux_if.master      m_axis,
    output logic [NUM_EGR*CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt,
    output logic                          md_overflow,
    output logic                          md_underrun
);

    localparam egr_idx_t NUM_EGR_IDX = egr_idx_t'(NUM_EGR);
    localparam int       FIFO_CW     = $clog2(MD_FIFO_DEPTH) + 1;

    demux_state_t            state_q;
    demux_state_t            state_d;
    egr_idx_t                sel_q;
    egr_idx_t                sel_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    egr_idx_t                fifo_rd;
    logic [FIFO_CW-1:0]      fifo_count;

    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;

    logic                    out_valid;
    logic [8*DATA_BYTES-1:0] out_data;
    logic [DATA_BYTES-1:0]   out_keep;
    logic                    out_last;
    logic [NUM_EGR-1:0]      onehot;
    logic                    drain;
    logic                    can_load;
    logic                    accept_fwd;
    logic                    pkt_done;
    logic                    drop_done;

    logic [CNT_WIDTH-1:0]    pkt_cnt_q [NUM_EGR];
    logic [7:0]              wd_cnt;
    logic                    wd_run;
    logic                    unused_bits;

    assign unused_bits = ^{fifo_count, md_in.rsvd};

    p4_router_md_fifo #(
        .WIDTH (EGR_SPEC_ID_WIDTH),
        .DEPTH (MD_FIFO_DEPTH)
    ) u_md_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (md_in_valid),
        .wr_data (md_in.egress_spec),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign s_valid        = s_axis.tvalid[0];
    assign s_last         = s_axis.tlast;
    assign s_axis.tready  = s_ready;

    assign m_axis.tdata   = out_data;
    assign m_axis.tkeep   = out_keep;
    assign m_axis.tlast   = out_last;
    assign m_axis.tvalid  = onehot;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_EGR; i++) begin
            onehot[i] = out_valid && (sel_q == egr_idx_t'(i));
        end
    end

    // sel_q belongs to the output register until its last beat leaves, so a
    // new packet may only claim it when the register is empty or draining.
    assign drain      = |(onehot & m_axis.tready);
    assign can_load   = !out_valid || drain;
    assign accept_fwd = (state_q == DEMUX_FWD) && s_valid && s_ready;
    assign pkt_done   = accept_fwd && s_last;
    assign drop_done  = (state_q == DEMUX_DROP) && s_valid && s_last;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= DEMUX_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        fifo_pop = 1'b0;
        s_ready  = 1'b0;
        case (state_q)
            DEMUX_IDLE: begin
                if (!fifo_empty && can_load) begin
                    fifo_pop = 1'b1;
                    sel_d    = fifo_rd;
                    state_d  = egr_is_valid(fifo_rd, NUM_EGR_IDX) ? DEMUX_FWD : DEMUX_DROP;
                end
            end
            DEMUX_FWD: begin
                s_ready = can_load;
                if (s_valid && s_ready && s_last) begin
                    state_d = DEMUX_IDLE;
                end
            end
            DEMUX_DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = DEMUX_IDLE;
                end
            end
            default: begin
                state_d = DEMUX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (accept_fwd) begin
            out_valid <= 1'b1;
            out_data  <= s_axis.tdata;
            out_keep  <= s_axis.tkeep;
            out_last  <= s_last;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_EGR; i++) begin
                pkt_cnt_q[i] <= '0;
            end
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_EGR; i++) begin
                if (pkt_done && (sel_q == egr_idx_t'(i))) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + CNT_WIDTH'(1);
                end
            end
            if (drop_done) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_EGR; g++) begin : g_pkt_cnt
        assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[g];
    end

    // Watchdog counts cycles a beat sits at IDLE with no metadata queued.
    assign wd_run = (state_q == DEMUX_IDLE) && s_valid && fifo_empty;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt      <= '0;
            md_underrun <= 1'b0;
            md_overflow <= 1'b0;
        end else begin
            if (!wd_run) begin
                wd_cnt <= '0;
            end else if (wd_cnt != 8'hFF) begin
                wd_cnt <= wd_cnt + 8'd1;
            end else begin
                md_underrun <= 1'b1;
            end
            if (md_in_valid && fifo_full) begin
                md_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// Directed bench for p4_router_egress_demux: forwarding, drop, backpressure,
// metadata ordering, overflow/underrun flags and async reset mid-packet.
module tb_p4_router_egress_demux;
    import p4_router_pkg::*;

    logic                     clk = 1'b0;
    logic                     aresetn;
    USER_META_DATA_METADATA_T md_in;
    logic                     md_in_valid;
    logic [11*32-1:0]         pkt_cnt;
    logic [31:0]              drop_cnt;
    logic                     md_overflow;
    logic                     md_underrun;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    logic [63:0] mon_data [$];
    logic [7:0]  mon_keep [$];
    logic        mon_last [$];
    int          mon_port [$];
    int          mon_cycle[$];
    int          acc_q    [$];

    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [10:0] prev_valid;
    logic        bp_done;
    int          st;

    p4_router_egress_demux_if #(.DATA_BYTES(8), .VALID_W(1))  s_if ();
    p4_router_egress_demux_if #(.DATA_BYTES(8), .VALID_W(11)) m_if ();

    p4_router_egress_demux #(
        .DATA_BYTES    (8),
        .NUM_EGR       (11),
        .MD_FIFO_DEPTH (4),
        .CNT_WIDTH     (32)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .md_in       (md_in),
        .md_in_valid (md_in_valid),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .pkt_cnt     (pkt_cnt),
        .drop_cnt    (drop_cnt),
        .md_overflow (md_overflow),
        .md_underrun (md_underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] get_pkt(input int p);
        return pkt_cnt[p*32 +: 32];
    endfunction

    // Egress monitor: records accepted beats and checks AXIS hold under stall.
    always begin
        @(negedge clk);
        #4;
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_data", m_if.tdata, prev_data);
                checkOutput("hold_valid", 64'(m_if.tvalid), 64'(prev_valid));
            end
            if (|m_if.tvalid) begin
                checkOutput("onehot", 64'($onehot(m_if.tvalid)), 64'd1);
            end
            if (|(m_if.tvalid & m_if.tready)) begin
                for (int p = 0; p < 11; p++) begin
                    if (m_if.tvalid[p]) mon_port.push_back(p);
                end
                mon_data.push_back(m_if.tdata);
                mon_keep.push_back(m_if.tkeep);
                mon_last.push_back(m_if.tlast);
                mon_cycle.push_back(cycle);
            end
            prev_stall = (|m_if.tvalid) && !(|(m_if.tvalid & m_if.tready));
            prev_data  = m_if.tdata;
            prev_valid = m_if.tvalid;
        end
    end

    task automatic clearMonitor();
        mon_data.delete();
        mon_keep.delete();
        mon_last.delete();
        mon_port.delete();
        mon_cycle.delete();
        acc_q.delete();
    endtask

    task automatic pushMd(input logic [7:0] egr);
        @(negedge clk);
        md_in             = '0;
        md_in.egress_spec = egr;
        md_in_valid       = 1'b1;
        @(negedge clk);
        md_in_valid       = 1'b0;
    endtask

    task automatic sendBeat(input logic [63:0] data, input logic [7:0] keep, input logic last,
                            output int stalls, output int acc_cyc);
        logic done;
        done    = 1'b0;
        stalls  = 0;
        acc_cyc = -1;
        @(negedge clk);
        s_if.tdata  = data;
        s_if.tkeep  = keep;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            #4;
            if (s_if.tready[0]) begin
                done    = 1'b1;
                acc_cyc = cycle;
            end else begin
                stalls++;
            end
            @(posedge clk);
            if (done) break;
            @(negedge clk);
        end
        checkOutput("beat_accept", 64'(done), 64'd1);
    endtask

    task automatic applyStimulus(input int nbeats, input logic [63:0] base, input logic [7:0] last_keep,
                                 output int late_stalls);
        int s;
        int a;
        late_stalls = 0;
        for (int b = 0; b < nbeats; b++) begin
            sendBeat(base + 64'(b), (b == nbeats - 1) ? last_keep : 8'hFF, b == nbeats - 1, s, a);
            acc_q.push_back(a);
            if (b > 0) late_stalls += s;
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic checkPacket(input int first, input int n, input logic [63:0] base,
                               input int port, input logic [7:0] last_keep);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = first + i;
            checkOutput("beat_present", 64'(mon_data.size() > idx), 64'd1);
            if (mon_data.size() > idx) begin
                checkOutput("beat_data", mon_data[idx], base + 64'(i));
                checkOutput("beat_port", 64'(mon_port[idx]), 64'(port));
                checkOutput("beat_keep", 64'(mon_keep[idx]), 64'((i == n - 1) ? last_keep : 8'hFF));
                checkOutput("beat_last", 64'(mon_last[idx]), 64'(i == n - 1));
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        aresetn     = 1'b0;
        md_in       = '0;
        md_in_valid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = '1;
        repeat (3) @(negedge clk);
        #4;
        checkOutput("rst_s_tready", 64'(s_if.tready), 64'd0);
        checkOutput("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        checkOutput("rst_m_tdata", m_if.tdata, 64'd0);
        checkOutput("rst_pkt_cnt3", 64'(get_pkt(3)), 64'd0);
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        checkOutput("rst_flags", 64'({md_overflow, md_underrun}), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;

        $display("[TB] basic forward to port 3");
        clearMonitor();
        pushMd(8'd3);
        applyStimulus(3, 64'h1000, 8'h0F, st);
        repeat (3) @(negedge clk);
        #4;
        checkOutput("fwd_count", 64'(mon_data.size()), 64'd3);
        checkPacket(0, 3, 64'h1000, 3, 8'h0F);
        if (mon_cycle.size() == 3 && acc_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("fwd_latency", 64'(mon_cycle[i] - acc_q[i]), 64'd1);
            end
        end
        checkOutput("fwd_pkt_cnt3", 64'(get_pkt(3)), 64'd1);

        $display("[TB] drop on 0xFF and on index 11");
        clearMonitor();
        pushMd(8'hFF);
        applyStimulus(4, 64'h2000, 8'hFF, st);
        checkOutput("drop_ff_stalls", 64'(st), 64'd0);
        pushMd(8'd11);
        applyStimulus(2, 64'h2100, 8'h03, st);
        checkOutput("drop_11_stalls", 64'(st), 64'd0);
        repeat (3) @(negedge clk);
        #4;
        checkOutput("drop_no_output", 64'(mon_data.size()), 64'd0);
        checkOutput("drop_cnt", 64'(drop_cnt), 64'd2);

        $display("[TB] backpressure on port 7");
        clearMonitor();
        pushMd(8'd7);
        bp_done = 1'b0;
        fork
            begin
                applyStimulus(5, 64'h3000, 8'h7F, st);
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(negedge clk);
                    m_if.tready[7] = ~m_if.tready[7];
                end
            end
        join
        m_if.tready = '1;
        repeat (4) @(negedge clk);
        #4;
        checkOutput("bp_count", 64'(mon_data.size()), 64'd5);
        checkPacket(0, 5, 64'h3000, 7, 8'h7F);
        checkOutput("bp_pkt_cnt7", 64'(get_pkt(7)), 64'd1);

        $display("[TB] metadata queued ahead, then late metadata");
        clearMonitor();
        pushMd(8'd0);
        pushMd(8'd1);
        pushMd(8'd2);
        pushMd(8'd10);
        applyStimulus(2, 64'h4000, 8'hFF, st);
        applyStimulus(2, 64'h4010, 8'hFF, st);
        applyStimulus(2, 64'h4020, 8'hFF, st);
        applyStimulus(2, 64'h4030, 8'hFF, st);
        fork
            applyStimulus(1, 64'h5000, 8'h01, st);
            begin
                repeat (20) @(negedge clk);
                #4;
                checkOutput("late_waits", 64'(s_if.tready), 64'd0);
                pushMd(8'd4);
            end
        join
        repeat (3) @(negedge clk);
        #4;
        checkOutput("order_count", 64'(mon_data.size()), 64'd9);
        checkPacket(0, 2, 64'h4000, 0, 8'hFF);
        checkPacket(2, 2, 64'h4010, 1, 8'hFF);
        checkPacket(4, 2, 64'h4020, 2, 8'hFF);
        checkPacket(6, 2, 64'h4030, 10, 8'hFF);
        checkPacket(8, 1, 64'h5000, 4, 8'h01);
        checkOutput("late_no_underrun", 64'(md_underrun), 64'd0);
        checkOutput("pkt_cnt10", 64'(get_pkt(10)), 64'd1);

        $display("[TB] metadata overflow and underrun watchdog");
        clearMonitor();
        pushMd(8'd3);
        for (int k = 0; k < 4; k++) pushMd(8'd9);
        #4;
        checkOutput("ovf_after_4", 64'(md_overflow), 64'd0);
        pushMd(8'd9);
        #4;
        checkOutput("ovf_after_5", 64'(md_overflow), 64'd1);
        for (int k = 0; k < 5; k++) applyStimulus(1, 64'h6000 + 64'(k), 8'h01, st);
        repeat (3) @(negedge clk);
        #4;
        checkOutput("ovf_pkt_cnt9", 64'(get_pkt(9)), 64'd4);
        checkOutput("ovf_pkt_cnt3", 64'(get_pkt(3)), 64'd2);
        checkOutput("ovf_beats", 64'(mon_data.size()), 64'd5);
        @(negedge clk);
        s_if.tdata  = 64'h7000;
        s_if.tkeep  = 8'hFF;
        s_if.tlast  = 1'b1;
        s_if.tvalid = 1'b1;
        repeat (250) @(negedge clk);
        #4;
        checkOutput("udr_at_250", 64'(md_underrun), 64'd0);
        checkOutput("udr_no_ready", 64'(s_if.tready), 64'd0);
        repeat (50) @(negedge clk);
        #4;
        checkOutput("udr_at_300", 64'(md_underrun), 64'd1);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;

        $display("[TB] async reset during beat 2 to port 5");
        clearMonitor();
        pushMd(8'd5);
        begin
            int a;
            sendBeat(64'h8000, 8'hFF, 1'b0, st, a);
        end
        @(negedge clk);
        s_if.tdata  = 64'h8001;
        s_if.tvalid = 1'b1;
        #1;
        checkOutput("pre_rst_valid", 64'(m_if.tvalid), 64'h20);
        #1;
        aresetn = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 64'(m_if.tvalid), 64'd0);
        checkOutput("rst_mid_ready", 64'(s_if.tready), 64'd0);
        checkOutput("rst_mid_pkt3", 64'(get_pkt(3)), 64'd0);
        checkOutput("rst_mid_pkt9", 64'(get_pkt(9)), 64'd0);
        checkOutput("rst_mid_drop", 64'(drop_cnt), 64'd0);
        checkOutput("rst_mid_flags", 64'({md_overflow, md_underrun}), 64'd0);
        @(negedge clk);
        aresetn     = 1'b1;
        s_if.tvalid = 1'b0;
        clearMonitor();
        pushMd(8'd6);
        applyStimulus(2, 64'h9000, 8'h03, st);
        repeat (3) @(negedge clk);
        #4;
        checkOutput("post_rst_count", 64'(mon_data.size()), 64'd2);
        checkPacket(0, 2, 64'h9000, 6, 8'h03);
        checkOutput("post_rst_pkt6", 64'(get_pkt(6)), 64'd1);
        checkOutput("post_rst_pkt5", 64'(get_pkt(5)), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/p4_router_egress_demux.md
Name: p4_router_egress_demux

Overview:
- Sits directly downstream of the VNP4 wrapper. Consumes its output packet stream and the per-packet user metadata, which is already mapped to RTL egress indices.
- Steers each whole packet to one of NUM_EGR egress AXIS ports and drops packets whose egress index is invalid.
- Buffers metadata so it can arrive before or during its packet, and provides per-port packet counters and a drop counter for status registers.

Parameters:
- DATA_BYTES, 8, tdata width in bytes; matches VNP4 output.
- NUM_EGR, 11, number of egress ports; indices 0..NUM_EGR-1 match p4_router_pkg egress enum.
- MD_FIFO_DEPTH, 4, metadata FIFO depth; power of 2, ≥2.
- CNT_WIDTH, 32, counter width.

Ports:
- clk  in  1  single clock for everything.
- aresetn  in  1  asynchronous active-low reset.
- md_in  in  USER_METADATA_WIDTH  USER_META_DATA_METADATA_T; egress spec in [0 +: EGR_SPEC_ID_WIDTH].
- md_in_valid  in  1  one-cycle metadata strobe, one per packet.
- s_tdata  in  8*DATA_BYTES  packet data from VNP4.
- s_tkeep  in  DATA_BYTES  byte enables.
- s_tlast  in  1  end of packet.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat accept.
- m_tdata  out  8*DATA_BYTES  shared egress data, broadcast to all ports.
- m_tkeep  out  DATA_BYTES  shared egress keep.
- m_tlast  out  1  shared egress last.
- m_tvalid  out  NUM_EGR  one-hot valid per egress port.
- m_tready  in  NUM_EGR  per-port ready.
- pkt_cnt  out  NUM_EGR*CNT_WIDTH  packets forwarded per port.
- drop_cnt  out  CNT_WIDTH  packets dropped for invalid egress.
- md_overflow  out  1  sticky; metadata arrived while the FIFO was full.
- md_underrun  out  1  sticky; a packet beat was waiting at IDLE for more than 255 cycles with no metadata.

Behaviour:
- Reset values:
  - s_tready=0, m_tvalid=0, m_tdata/m_tkeep/m_tlast=0.
  - All counters 0, sticky flags 0.
  - Metadata FIFO empty, FSM in IDLE.
- Metadata FIFO:
  - Write on md_in_valid when not full.
  - When full, md_in_valid discards the entry and sets md_overflow.
  - Pop occurs in IDLE on the transition out of IDLE.
  - Write and pop in the same cycle are both honoured; occupancy is unchanged.
- FSM states: IDLE, FWD, DROP.
  - IDLE:
    - s_tready=0.
    - If the FIFO is non-empty, pop it and latch sel = egress spec.
    - If sel < NUM_EGR, go to FWD; otherwise (including 0xFF) go to DROP.
    - Exactly one cycle is spent in IDLE between packets.
  - FWD:
    - s_tready = !out_valid || m_tready[sel_q].
    - An accepted beat loads the output register.
    - A beat accepted with s_tlast → IDLE, and pkt_cnt[sel_q] increments.
  - DROP:
    - s_tready=1; beats are consumed and discarded.
    - tlast accepted → IDLE, and drop_cnt increments.
- Output register:
  - Single stage; latency 1 cycle from s_tvalid&&s_tready to m_tvalid[sel_q].
  - m_tvalid is one-hot at bit sel_q when out_valid; all other bits are 0.
  - Data holds stable while m_tvalid[sel_q] && !m_tready[sel_q] (AXIS rule).
  - sel_q remains valid for the output register until its last beat drains; a new packet's sel may load only when the register is empty or draining its final beat the same cycle.
- Underrun watchdog: 8-bit counter runs while in IDLE && s_tvalid && FIFO empty; saturates and sets md_underrun. No packet data is ever consumed without metadata.
- Counters wrap modulo 2^CNT_WIDTH.
- Zero-length packets cannot occur: every packet has ≥1 beat, and tkeep is passed unmodified.
- Reset mid-packet: all state is cleared immediately and async.
  - After reset the block takes the next beat as a packet start, consuming FIFO metadata as normal.
  - Upstream flush is the upstream's responsibility.

Decomposition:
- Add to p4_router_pkg:
  - NUM_EGR_PORTS=11.
  - typedef egr_idx_t (logic [EGR_SPEC_ID_WIDTH-1:0]).
  - EGR_DROP_ID = 8'hFF.
- Reuse USER_META_DATA_METADATA_T and EGR_SPEC_ID_WIDTH.
- One sub-module: p4_router_md_fifo. It is a synchronous FIFO with async reset and full/empty/occupancy outputs, reusable by the ingress-side stage.

Test Plan:
- Basic forward:
  - Stimulus: md egr=3, then a 3-beat packet with tkeep last=8'h0F, m_tready all 1.
  - Response: 3 beats on m_tvalid=11'b00000001000, tkeep preserved, latency 1, pkt_cnt[3]=1.
- Drop:
  - Stimulus: md egr=8'hFF then a 4-beat packet; separately md egr=11.
  - Response: s_tready=1 throughout, no m_tvalid, drop_cnt=2.
- Backpressure:
  - Stimulus: egr=7, m_tready[7] toggled 1/0 every cycle over 5 beats.
  - Response: m_tdata stable while stalled, all 5 beats delivered in order, no duplicates.
- Metadata ahead of and behind data:
  - Stimulus: 4 md strobes (egr 0,1,2,10) queued before any data, then 4 packets; then one packet presented 20 cycles before its md.
  - Response: packets map in order, late packet waits in IDLE with s_tready=0, md_underrun stays 0.
- Overflow and underrun:
  - Stimulus: 5 md strobes with no data, then 300 cycles of s_tvalid with an empty FIFO.
  - Response: md_overflow=1 after the 5th strobe, md_underrun=1 after 255 cycles.
- Async reset mid-packet:
  - Stimulus: aresetn low for 1 cycle during beat 2 of egr=5.
  - Response: m_tvalid=0 immediately, counters 0, FIFO empty; the next md+packet forwards correctly.
